// File: rtl/sisc_pkg.sv
// sisc_pkg: shared types and constants for the SISC memory arbiter slice.
// Holds the arbiter state encoding, the owner encoding and default widths.
package sisc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 32;

    // Width of a down-counter that must hold values 0..lat-1, never below 1 bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: chooses which requester owns the next memory access.
// Build option MEM_ARB_RR_EN selects round-robin on ties; otherwise the
// data requester always wins over instruction fetch.
module mem_arb_pick
    import sisc_pkg::*;
(
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic last_own_i,
    output logic grant_o,
    output logic own_o
);

    assign grant_o = if_req_i | dm_req_i;

`ifdef MEM_ARB_RR_EN
    // On a tie hand the grant to whoever was not served last; a lone request wins outright.
    always_comb begin
        own_o = OWN_IF;
        if (if_req_i && dm_req_i) begin
            own_o = (last_own_i == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (dm_req_i) begin
            own_o = OWN_DM;
        end
    end
`else
    logic unusedLastOwn;
    assign unusedLastOwn = last_own_i;

    // Fixed priority: the in-flight instruction's load/store goes ahead of the next fetch.
    always_comb begin
        own_o = dm_req_i ? OWN_DM : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-port memory arbiter and access sequencer for SISC.
// Shares one synchronous memory between fetch and data requesters, holds
// the access stable for MEM_LAT cycles and pulses the owner's done.
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration on ties).
module mem_arb
    import sisc_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int            CW       = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] ifRdata_q, ifRdata_d;
    logic [DW-1:0] dmRdata_q, dmRdata_d;

    logic grant;
    logic pickOwn;
    logic lastOwn;

    mem_arb_pick u_pick (
        .if_req_i   (if_req),
        .dm_req_i   (dm_req),
        .last_own_i (lastOwn),
        .grant_o    (grant),
        .own_o      (pickOwn)
    );

`ifdef MEM_ARB_RR_EN
    logic lastOwn_q, lastOwn_d;

    assign lastOwn_d = (state_q == IDLE && grant) ? pickOwn : lastOwn_q;
    assign lastOwn   = lastOwn_q;

    // Remember the owner of every grant so the next tie goes the other way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastOwn_q <= OWN_IF;
        end else begin
            lastOwn_q <= lastOwn_d;
        end
    end
`else
    assign lastOwn = OWN_IF;
`endif

    // Next-state logic: grant and latch in IDLE, count down in ACCESS, pulse in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ifRdata_d = ifRdata_q;
        dmRdata_d = dmRdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = pickOwn;
                    if (pickOwn == OWN_DM) begin
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DM) begin
                            dmRdata_d = mem_rdata;
                        end else begin
                            ifRdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, latched access and read-data registers; reset abandons any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ifRdata_q <= '0;
            dmRdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ifRdata_q <= ifRdata_d;
            dmRdata_q <= dmRdata_d;
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign if_done   = (state_q == DONE) && (owner_q == OWN_IF);
    assign dm_done   = (state_q == DONE) && (owner_q == OWN_DM);
    assign if_rdata  = ifRdata_q;
    assign dm_rdata  = dmRdata_q;

endmodule
